// File: rtl/imem_uart_loader.sv
// UART bootloader: receives a length/data/checksum frame, writes little-endian
// words into instruction SRAM port 0, then releases the core via core_run.
module imem_uart_loader #(
  parameter int CLKS_PER_BIT   = 347,
  parameter int ADDR_W         = 9,
  parameter int TIMEOUT_CYCLES = 400000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n,
  input  logic              uart_rx,
  input  logic              load_req,
  output logic              sram_csb0,
  output logic              sram_web0,
  output logic [ADDR_W-1:0] sram_addr0,
  output logic [31:0]       sram_din0,
  output logic [3:0]        sram_wmask0,
  output logic              core_run,
  output logic              load_busy,
  output logic [2:0]        load_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [TO_W-1:0]  TO_M1   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]      MAX_WORDS = 17'd1 << ADDR_W;

  localparam logic [2:0] E_FRAME = 3'd1;
  localparam logic [2:0] E_CSUM  = 3'd2;
  localparam logic [2:0] E_LEN   = 3'd3;
  localparam logic [2:0] E_TIME  = 3'd4;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_t;
  typedef enum logic [2:0] {S_IDLE, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERR} st_t;

  // ---------------- UART receiver ----------------
  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  rx_st_t           rx_st_q, rx_st_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             rx_valid_q, rx_valid_d, rx_ferr_q, rx_ferr_d;

  always_comb begin
    rx_st_d    = rx_st_q;
    bit_cnt_d  = bit_cnt_q + 1'b1;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = 1'b0;
    case (rx_st_q)
      RX_IDLE: begin
        bit_cnt_d = '0;
        // edge-triggered so a low stop bit cannot immediately retrigger
        if (rx_prev_q && !rx_sync_q) rx_st_d = RX_START;
      end
      RX_START: if (bit_cnt_q == HALF_M1) begin
        bit_cnt_d = '0;
        bit_idx_d = '0;
        rx_st_d   = rx_sync_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (bit_cnt_q == BIT_M1) begin
        bit_cnt_d = '0;
        shreg_d   = {rx_sync_q, shreg_q[7:1]};
        bit_idx_d = bit_idx_q + 1'b1;
        if (bit_idx_q == 3'd7) rx_st_d = RX_STOP;
      end
      RX_STOP: if (bit_cnt_q == BIT_M1) begin
        rx_st_d    = RX_IDLE;
        rx_valid_d = rx_sync_q;
        rx_ferr_d  = !rx_sync_q;
      end
      default: rx_st_d = RX_IDLE;
    endcase
    if (load_req) begin
      rx_st_d    = RX_IDLE;
      rx_valid_d = 1'b0;
      rx_ferr_d  = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_st_q    <= RX_IDLE;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_meta_q  <= uart_rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_st_q    <= rx_st_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  // ---------------- frame parser / SRAM writer ----------------
  st_t               st_q, st_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [1:0]        lane_q, lane_d;
  logic [31:0]       word_q, word_d;
  logic [7:0]        sum_q, sum_d;
  logic [TO_W-1:0]   idle_q, idle_d;
  logic              csb_q, csb_d, web_q, web_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       din_q, din_d;
  logic [3:0]        wmask_q, wmask_d;
  logic              run_q, run_d, busy_q, busy_d;
  logic [2:0]        err_q, err_d;
  logic [ADDR_W:0]   words_q, words_d, words_inc;
  logic [15:0]       len_n;
  logic              load_act;

  always_comb begin
    st_d     = st_q;
    len_lo_d = len_lo_q;
    len_d    = len_q;
    lane_d   = lane_q;
    word_d   = word_q;
    sum_d    = sum_q;
    addr_d   = addr_q;
    din_d    = din_q;
    run_d    = run_q;
    busy_d   = busy_q;
    err_d    = err_q;
    words_d  = words_q;
    csb_d    = 1'b1;
    web_d    = 1'b1;
    wmask_d  = 4'h0;
    len_n     = {shreg_q, len_lo_q};
    words_inc = words_q + 1'b1;
    load_act  = (st_q == S_LEN_HI) || (st_q == S_DATA) || (st_q == S_CSUM);
    // counts cycles elapsed since the last accepted byte
    idle_d    = (rx_valid_q || !load_act) ? TO_W'(1) : idle_q + 1'b1;
    // advance after each write, but never past the last word
    if (!csb_q && words_q != len_q) addr_d = addr_q + 1'b1;

    case (st_q)
      S_IDLE: if (rx_valid_q) begin
        len_lo_d = shreg_q;
        busy_d   = 1'b1;
        run_d    = 1'b0;
        err_d    = '0;
        words_d  = '0;
        sum_d    = '0;
        lane_d   = '0;
        addr_d   = '0;
        st_d     = S_LEN_HI;
      end
      S_LEN_HI: if (rx_valid_q) begin
        if (len_n == 16'd0 || {1'b0, len_n} > MAX_WORDS) begin
          st_d   = S_ERR;
          err_d  = E_LEN;
          busy_d = 1'b0;
        end else begin
          len_d = len_n[ADDR_W:0];
          st_d  = S_DATA;
        end
      end
      S_DATA: if (rx_valid_q) begin
        word_d = {shreg_q, word_q[31:8]};
        sum_d  = sum_q + shreg_q;
        lane_d = lane_q + 1'b1;
        if (lane_q == 2'd3) begin
          csb_d   = 1'b0;
          web_d   = 1'b0;
          wmask_d = 4'hF;
          din_d   = {shreg_q, word_q[31:8]};
          words_d = words_inc;
          if (words_inc == len_q) st_d = S_CSUM;
        end
      end
      S_CSUM: if (rx_valid_q) begin
        busy_d = 1'b0;
        if (shreg_q == sum_q) begin
          st_d  = S_DONE;
          run_d = 1'b1;
        end else begin
          st_d  = S_ERR;
          err_d = E_CSUM;
        end
      end
      default: ;
    endcase

    if (load_act && rx_ferr_q) begin
      st_d   = S_ERR;
      err_d  = E_FRAME;
      busy_d = 1'b0;
    end
    if (load_act && !rx_valid_q && idle_q == TO_M1) begin
      st_d   = S_ERR;
      err_d  = E_TIME;
      busy_d = 1'b0;
    end

    if (load_req) begin
      st_d    = S_IDLE;
      run_d   = 1'b0;
      busy_d  = 1'b0;
      err_d   = '0;
      words_d = '0;
      addr_d  = '0;
      lane_d  = '0;
      csb_d   = 1'b1;
      web_d   = 1'b1;
      wmask_d = 4'h0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      st_q     <= S_IDLE;
      len_lo_q <= '0;
      len_q    <= '0;
      lane_q   <= '0;
      word_q   <= '0;
      sum_q    <= '0;
      idle_q   <= TO_W'(1);
      csb_q    <= 1'b1;
      web_q    <= 1'b1;
      addr_q   <= '0;
      din_q    <= '0;
      wmask_q  <= 4'h0;
      run_q    <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= '0;
      words_q  <= '0;
    end else begin
      st_q     <= st_d;
      len_lo_q <= len_lo_d;
      len_q    <= len_d;
      lane_q   <= lane_d;
      word_q   <= word_d;
      sum_q    <= sum_d;
      idle_q   <= idle_d;
      csb_q    <= csb_d;
      web_q    <= web_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      wmask_q  <= wmask_d;
      run_q    <= run_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      words_q  <= words_d;
    end
  end

  assign sram_csb0    = csb_q;
  assign sram_web0    = web_q;
  assign sram_addr0   = addr_q;
  assign sram_din0    = din_q;
  assign sram_wmask0  = wmask_q;
  assign core_run     = run_q;
  assign load_busy    = busy_q;
  assign load_err     = err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader: a frame-level model predicts SRAM writes
// and final status; a negedge monitor checks every write cycle against it.
module tb_imem_uart_loader;
  localparam int CPB = 8;
  localparam int AW  = 4;
  localparam int TO  = 300;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_n = 1'b1;
  logic          uart_rx  = 1'b1;
  logic          load_req = 1'b0;
  logic          sram_csb0, sram_web0;
  logic [AW-1:0] sram_addr0;
  logic [31:0]   sram_din0;
  logic [3:0]    sram_wmask0;
  logic          core_run, load_busy;
  logic [2:0]    load_err;
  logic [AW:0]   words_loaded;

  imem_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_n(wb_rst_n), .uart_rx(uart_rx), .load_req(load_req),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_addr0(sram_addr0),
    .sram_din0(sram_din0), .sram_wmask0(sram_wmask0), .core_run(core_run),
    .load_busy(load_busy), .load_err(load_err), .words_loaded(words_loaded));

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct packed { logic [AW-1:0] addr; logic [31:0] data; } wr_t;
  wr_t        exp_q[$];
  logic [7:0] frm[$];
  int         stop_q[$];
  int         wr_cyc[$];
  int         cyc = 0, checks = 0, errors = 0, run_rise = -1, dlat = 0;
  logic       prev_csb = 1'b1, prev_run = 1'b0;

  always @(posedge wb_clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // per-cycle monitor against the expected-write queue
  always @(negedge wb_clk_i) begin
    if (wb_rst_n === 1'b1) begin
      if (sram_csb0 === 1'b0) begin
        wr_t e;
        wr_cyc.push_back(cyc);
        chk("wr_single_cycle", prev_csb, 1);
        chk("wr_web", sram_web0, 0);
        chk("wr_wmask", sram_wmask0, 4'hF);
        chk("wr_expected_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("wr_addr", sram_addr0, e.addr);
          chk("wr_din", sram_din0, e.data);
        end
      end else begin
        chk("idle_web", sram_web0, 1);
        chk("idle_wmask", sram_wmask0, 0);
      end
      if (core_run === 1'b1) chk("run_clean", {load_busy, load_err}, 0);
      if (core_run === 1'b1 && prev_run === 1'b0) run_rise = cyc;
      prev_csb = sram_csb0;
      prev_run = core_run;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge wb_clk_i);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v = 1'b1, input bit full_stop = 1'b1);
    uart_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(CPB);
    end
    stop_q.push_back(cyc);
    uart_rx = stop_v;
    if (full_stop) begin
      tick(CPB);
      uart_rx = 1'b1;
    end
  endtask

  task automatic send_frame();
    tick(1);
    stop_q.delete();
    foreach (frm[i]) send_byte(frm[i]);
  endtask

  // frame-level reference: what a loader obeying the frame rules must do
  task automatic model_frame(output int err, output bit run, output int nw);
    int n;
    logic [7:0] sum;
    wr_t w;
    err = 0; run = 0; nw = 0; sum = 8'h00;
    n = int'({frm[1], frm[0]});
    if (n == 0 || n > (1 << AW)) begin err = 3; return; end
    for (int i = 0; i < n; i++) begin
      if (frm.size() < 2 + 4 * i + 4) begin err = 4; return; end
      w.addr = AW'(i);
      w.data = {frm[2+4*i+3], frm[2+4*i+2], frm[2+4*i+1], frm[2+4*i]};
      for (int k = 0; k < 4; k++) sum = sum + frm[2+4*i+k];
      exp_q.push_back(w);
      nw = i + 1;
    end
    if (frm.size() < 3 + 4 * n) err = 4;
    else if (frm[2+4*n] != sum) err = 2;
    else run = 1;
  endtask

  task automatic run_frame(input string tag);
    int e_err, e_nw;
    bit e_run;
    model_frame(e_err, e_run, e_nw);
    wr_cyc.delete();
    run_rise = -1;
    send_frame();
    tick(2 * CPB);
    @(negedge wb_clk_i);
    chk({tag, "_err"}, load_err, e_err);
    chk({tag, "_run"}, core_run, e_run);
    chk({tag, "_words"}, words_loaded, e_nw);
    chk({tag, "_busy"}, load_busy, 0);
    chk({tag, "_writes_done"}, exp_q.size(), 0);
  endtask

  task automatic pulse_load_req();
    tick(1);
    load_req = 1'b1;
    tick(1);
    load_req = 1'b0;
    tick(2);
  endtask

  task automatic build_big(input int n, input bit good);
    logic [7:0] sum;
    logic [31:0] w;
    frm.delete();
    sum = 8'h00;
    frm.push_back(n[7:0]);
    frm.push_back(n[15:8]);
    for (int i = 0; i < n; i++) begin
      w = (32'h01020304 * (i + 1)) ^ 32'hA5A5_0000;
      for (int k = 0; k < 4; k++) begin
        frm.push_back(w[8*k +: 8]);
        sum = sum + w[8*k +: 8];
      end
    end
    frm.push_back(good ? sum : ~sum);
  endtask

  task automatic frame_a(input logic [7:0] csum);
    frm = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h00};
    frm[10] = csum;
  endtask

  task automatic wait_write();
    bit got = 0;
    for (int i = 0; i < 4 * CPB && !got; i++) begin
      @(negedge wb_clk_i);
      if (sram_csb0 === 1'b0) got = 1;
    end
    chk("write_wait", got, 1);
  endtask

  task automatic partial_word0();
    int e_err, e_nw;
    bit e_run;
    frm = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00};
    model_frame(e_err, e_run, e_nw);
    tick(1);
    for (int i = 0; i < 5; i++) send_byte(frm[i]);
    send_byte(frm[5], 1'b1, 1'b0);
    wait_write();
  endtask

  initial begin
    int e_err, e_nw, t_err;
    bit e_run;
    // reset values
    #2 wb_rst_n = 1'b0;
    repeat (3) @(negedge wb_clk_i);
    chk("rst_csb", sram_csb0, 1);   chk("rst_web", sram_web0, 1);
    chk("rst_addr", sram_addr0, 0); chk("rst_din", sram_din0, 0);
    chk("rst_wmask", sram_wmask0, 0); chk("rst_run", core_run, 0);
    chk("rst_busy", load_busy, 0);  chk("rst_err", load_err, 0);
    chk("rst_words", words_loaded, 0);
    @(posedge wb_clk_i); #1 wb_rst_n = 1'b1;
    tick(2);

    // good two-word frame; data byte sum = 0x97
    frame_a(8'h97);
    run_frame("frameA");
    chk("frameA_run_lit", core_run, 1);
    chk("frameA_words_lit", words_loaded, 2);
    chk("frameA_addr_hold", sram_addr0, 1);
    dlat = wr_cyc[0] - 1 - stop_q[5];
    chk("rx_latency_window", (dlat >= CPB / 2) && (dlat <= CPB / 2 + 4), 1);
    chk("write_spacing", wr_cyc[1] - wr_cyc[0], stop_q[9] - stop_q[5]);
    chk("run_latency", run_rise - stop_q[10], dlat + 1);
    // DONE ignores further bytes
    tick(1);
    send_byte(8'h55);
    tick(2 * CPB);
    @(negedge wb_clk_i);
    chk("done_ignore_run", core_run, 1);
    chk("done_ignore_words", words_loaded, 2);

    // bad checksum, then recovery
    pulse_load_req();
    frame_a(8'h00);
    run_frame("badcsum");
    chk("badcsum_err_lit", load_err, 2);
    pulse_load_req();
    frame_a(8'h97);
    run_frame("recover");

    // length bounds
    pulse_load_req();
    frm = '{8'h00, 8'h00};
    run_frame("len0");
    pulse_load_req();
    frm = '{8'h11, 8'h00};
    run_frame("lenmax1");
    chk("lenmax1_err_lit", load_err, 3);
    pulse_load_req();
    build_big(1 << AW, 1'b1);
    run_frame("lenmax");
    chk("lenmax_words_lit", words_loaded, 16);
    chk("lenmax_last_addr", sram_addr0, 4'hF);

    // framing error on the 4th data byte
    pulse_load_req();
    frame_a(8'h97);
    tick(1);
    for (int i = 0; i < 5; i++) send_byte(frm[i]);
    send_byte(frm[5], 1'b0);
    tick(2 * CPB);
    @(negedge wb_clk_i);
    chk("ferr_err", load_err, 1);
    chk("ferr_words", words_loaded, 0);
    chk("ferr_busy", load_busy, 0);
    chk("ferr_nowrite", exp_q.size(), 0);
    // framing error and start glitch while idle are ignored
    pulse_load_req();
    send_byte(8'h3C, 1'b0);
    uart_rx = 1'b0;
    tick(2);
    uart_rx = 1'b1;
    tick(4 * CPB);
    @(negedge wb_clk_i);
    chk("idle_ferr_err", load_err, 0);
    chk("idle_ferr_busy", load_busy, 0);
    frame_a(8'h97);
    run_frame("after_glitch");

    // timeout after 5 data bytes
    pulse_load_req();
    frm = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13};
    model_frame(e_err, e_run, e_nw);
    send_frame();
    t_err = stop_q[6] + dlat + TO;
    @(negedge wb_clk_i);
    while (cyc < t_err - 1) @(negedge wb_clk_i);
    chk("timeout_early", load_err, 0);
    @(negedge wb_clk_i);
    chk("timeout_err", load_err, e_err);
    chk("timeout_err_lit", load_err, 4);
    chk("timeout_busy", load_busy, 0);
    chk("timeout_words", words_loaded, e_nw);
    chk("timeout_writes_done", exp_q.size(), 0);

    // reset in the write cycle
    pulse_load_req();
    partial_word0();
    #1 wb_rst_n = 1'b0;
    #1;
    chk("arst_csb", sram_csb0, 1);   chk("arst_web", sram_web0, 1);
    chk("arst_addr", sram_addr0, 0); chk("arst_din", sram_din0, 0);
    chk("arst_wmask", sram_wmask0, 0); chk("arst_run", core_run, 0);
    chk("arst_busy", load_busy, 0);  chk("arst_err", load_err, 0);
    chk("arst_words", words_loaded, 0);
    tick(2);
    wb_rst_n = 1'b1;
    tick(2 * CPB);

    // load_req in the write cycle
    partial_word0();
    #1 load_req = 1'b1;
    @(negedge wb_clk_i);
    chk("lreq_csb", sram_csb0, 1);   chk("lreq_web", sram_web0, 1);
    chk("lreq_addr", sram_addr0, 0); chk("lreq_wmask", sram_wmask0, 0);
    chk("lreq_run", core_run, 0);    chk("lreq_busy", load_busy, 0);
    chk("lreq_err", load_err, 0);    chk("lreq_words", words_loaded, 0);
    tick(1);
    load_req = 1'b0;
    tick(2 * CPB);
    frame_a(8'h97);
    run_frame("after_lreq");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
